// File: rtl/stopwatch_core_pkg.sv
// Shared definitions for the stopwatch time-keeping core: digit width,
// default field limits, run/pause state encoding and BCD field step helper.
package stopwatch_core_pkg;

    localparam int DIGIT_W     = 4;
    localparam int MIN_MAX_DEF = 59;
    localparam int SEC_MAX_DEF = 59;

    localparam logic [0:0] ST_PAUSED = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

    typedef logic [DIGIT_W-1:0] bcd_t;

    // Next value of a two-digit BCD field; clears both digits at the field max.
    function automatic logic [2*DIGIT_W-1:0] bcd_field_next(
        input bcd_t tens,
        input bcd_t ones,
        input bcd_t max_tens,
        input bcd_t max_ones
    );
        logic [2*DIGIT_W-1:0] nxt;
        if ((tens == max_tens) && (ones == max_ones)) begin
            nxt = {4'd0, 4'd0};
        end else if (ones == 4'd9) begin
            nxt = {tens + 4'd1, 4'd0};
        end else begin
            nxt = {tens, ones + 4'd1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/stopwatch_core_bcd_field_counter.sv
// Two-digit BCD counter wrapping from MAX to 00; carry flags the wrapping increment.
module bcd_field_counter
    import stopwatch_core_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    input  logic               clr,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               carry
);

    localparam bcd_t MAX_TENS = bcd_t'(MAX / 10);
    localparam bcd_t MAX_ONES = bcd_t'(MAX % 10);

    bcd_t tens_q;
    bcd_t ones_q;
    bcd_t tens_d;
    bcd_t ones_d;
    logic at_max_s;

    assign at_max_s = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    assign carry    = inc && at_max_s;
    assign tens     = tens_q;
    assign ones     = ones_q;

    // Next-digit selection: clear beats increment.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (inc) begin
            {tens_d, ones_d} = bcd_field_next(tens_q, ones_q, MAX_TENS, MAX_ONES);
        end else begin
            tens_d = tens_q;
            ones_d = ones_q;
        end
    end

    // Digit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch MM:SS core: run/pause FSM, adjust-mode muxing and blink phase
// around two BCD field counters.
module stopwatch_core
    import stopwatch_core_pkg::*;
#(
    parameter int MIN_MAX = MIN_MAX_DEF,
    parameter int SEC_MAX = SEC_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               tick_2hz,
    input  logic               pause_vld,
    input  logic               clr_vld,
    input  logic               adj,
    input  logic               sel,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               running,
    output logic               blink
);

    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       blink_q;
    logic       blink_d;
    logic       sec_inc_s;
    logic       min_inc_s;
    logic       sec_carry_s;
    logic       min_carry_s;

    // Field increment muxing; seconds carry only ripples while counting.
    always_comb begin
        sec_inc_s = 1'b0;
        min_inc_s = 1'b0;
        if (adj) begin
            sec_inc_s = tick_2hz && sel;
            min_inc_s = tick_2hz && !sel;
        end else begin
            sec_inc_s = (state_q == ST_RUN) && tick_1hz;
            min_inc_s = sec_carry_s;
        end
    end

    // Run/pause toggle and blink phase next-state.
    always_comb begin
        state_d = state_q;
        blink_d = blink_q;
        if (pause_vld) begin
            state_d = ~state_q;
        end else begin
            state_d = state_q;
        end
        if (!adj) begin
            blink_d = 1'b0;
        end else if (tick_2hz) begin
            blink_d = ~blink_q;
        end else begin
            blink_d = blink_q;
        end
    end

    // FSM and blink registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_PAUSED;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            blink_q <= blink_d;
        end
    end

    assign running = (state_q == ST_RUN);
    assign blink   = blink_q;

    bcd_field_counter #(.MAX(SEC_MAX)) u_sec (
        .clk   (clk),
        .rst_n (rst),
        .inc   (sec_inc_s),
        .clr   (clr_vld),
        .tens  (sec_tens),
        .ones  (sec_ones),
        .carry (sec_carry_s)
    );

    bcd_field_counter #(.MAX(MIN_MAX)) u_min (
        .clk   (clk),
        .rst_n (rst),
        .inc   (min_inc_s),
        .clr   (clr_vld),
        .tens  (min_tens),
        .ones  (min_ones),
        .carry (min_carry_s)
    );

    // Minutes wrap carry has no consumer: overflow is intentionally not sticky.
    logic unused_s;
    assign unused_s = min_carry_s;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed self-checking bench for stopwatch_core with hand-computed MM:SS values.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       tick_2hz = 1'b0;
    logic       pause_vld = 1'b0;
    logic       clr_vld = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       blink;
    logic [15:0] disp;

    int checks   = 0;
    int failures = 0;

    stopwatch_core dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .tick_2hz  (tick_2hz),
        .pause_vld (pause_vld),
        .clr_vld   (clr_vld),
        .adj       (adj),
        .sel       (sel),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .running   (running),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    assign disp = {min_tens, min_ones, sec_tens, sec_ones};

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick1(input int n);
        tick_1hz = 1'b1;
        cyc(n);
        tick_1hz = 1'b0;
    endtask

    task automatic tick2(input int n);
        tick_2hz = 1'b1;
        cyc(n);
        tick_2hz = 1'b0;
    endtask

    task automatic pause_press();
        pause_vld = 1'b1;
        cyc(1);
        pause_vld = 1'b0;
    endtask

    initial begin
        #12;
        check_eq("reset_disp", disp, 16'h0000);
        check_eq("reset_running", {15'd0, running}, 16'd0);
        check_eq("reset_blink", {15'd0, blink}, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(2);
        check_eq("idle_paused", disp, 16'h0000);

        // 1: run and count 61 seconds
        pause_press();
        check_eq("t1_running", {15'd0, running}, 16'd1);
        tick1(61);
        check_eq("t1_0101", disp, 16'h0101);

        // 2: preload 59:58, then wrap to 00:00
        adj = 1'b1;
        sel = 1'b0;
        tick2(58);
        sel = 1'b1;
        tick2(57);
        adj = 1'b0;
        check_eq("t2_preload", disp, 16'h5958);
        tick1(1);
        check_eq("t2_5959", disp, 16'h5959);
        tick1(1);
        check_eq("t2_wrap", disp, 16'h0000);

        // 3: pause freezes the count
        tick1(5);
        check_eq("t3_0005", disp, 16'h0005);
        pause_press();
        check_eq("t3_paused", {15'd0, running}, 16'd0);
        tick1(10);
        check_eq("t3_frozen", disp, 16'h0005);
        pause_press();
        check_eq("t3_resumed", {15'd0, running}, 16'd1);
        tick1(1);
        check_eq("t3_0006", disp, 16'h0006);

        // 4: seconds adjust wraps without carry, blink phase
        adj = 1'b1;
        sel = 1'b1;
        tick2(52);
        check_eq("t4_0058", disp, 16'h0058);
        adj = 1'b0;
        cyc(1);
        check_eq("t4_blink_off", {15'd0, blink}, 16'd0);
        adj = 1'b1;
        tick2(1);
        check_eq("t4_0059", disp, 16'h0059);
        check_eq("t4_blink1", {15'd0, blink}, 16'd1);
        tick2(1);
        check_eq("t4_0000", disp, 16'h0000);
        check_eq("t4_blink0", {15'd0, blink}, 16'd0);
        tick2(1);
        check_eq("t4_0001", disp, 16'h0001);
        check_eq("t4_blink1b", {15'd0, blink}, 16'd1);
        tick1(1);
        check_eq("t4_1hz_ignored", disp, 16'h0001);
        adj = 1'b0;
        cyc(1);
        check_eq("t4_blink_exit", {15'd0, blink}, 16'd0);
        check_eq("t4_hold", disp, 16'h0001);

        // 5: clear with pause in the same cycle, clear beats tick
        adj = 1'b1;
        sel = 1'b0;
        tick2(12);
        sel = 1'b1;
        tick2(33);
        adj = 1'b0;
        check_eq("t5_1234", disp, 16'h1234);
        clr_vld = 1'b1;
        pause_vld = 1'b1;
        cyc(1);
        clr_vld = 1'b0;
        pause_vld = 1'b0;
        check_eq("t5_clr", disp, 16'h0000);
        check_eq("t5_paused", {15'd0, running}, 16'd0);
        pause_press();
        tick1(1);
        check_eq("t5_0001", disp, 16'h0001);
        clr_vld = 1'b1;
        tick1(1);
        clr_vld = 1'b0;
        check_eq("t5_clr_wins", disp, 16'h0000);

        // 6: async reset mid-operation at 03:07 in adjust mode
        adj = 1'b1;
        sel = 1'b0;
        tick2(3);
        adj = 1'b0;
        cyc(1);
        adj = 1'b1;
        sel = 1'b1;
        tick2(7);
        check_eq("t6_0307", disp, 16'h0307);
        check_eq("t6_blink_pre", {15'd0, blink}, 16'd1);
        check_eq("t6_running_pre", {15'd0, running}, 16'd1);
        #3;
        rst = 1'b0;
        #1;
        check_eq("t6_rst_disp", disp, 16'h0000);
        check_eq("t6_rst_running", {15'd0, running}, 16'd0);
        check_eq("t6_rst_blink", {15'd0, blink}, 16'd0);
        #2;
        rst = 1'b1;
        adj = 1'b0;
        cyc(1);
        check_eq("t6_after", disp, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
